// File: rtl/store_monitor_pkg.sv
// Shared definitions for the store monitor: word width, completion-check
// defaults and the done/fail state encoding.
package store_monitor_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEF_DONE_ADDR = 32'd84;
    localparam logic [WORD_W-1:0] DEF_DONE_DATA = 32'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } chk_state_e;

endpackage

// File: rtl/store_monitor_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Storage is not reset; only the
// pointers and occupancy are. Head reads 0 while empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop     = rd_en && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign push    = wr_en && (!full || pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/store_monitor.sv
// Passive snoop of the processor store bus: buffers in-window stores for a
// valid/ready trace sink and latches the first completion-address verdict.
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter int                DEPTH     = 8,
    parameter logic [WORD_W-1:0] WIN_LO    = 32'h0000_0000,
    parameter logic [WORD_W-1:0] WIN_HI    = 32'hFFFF_FFFF,
    parameter logic [WORD_W-1:0] DONE_ADDR = DEF_DONE_ADDR,
    parameter logic [WORD_W-1:0] DONE_DATA = DEF_DONE_DATA
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   memwrite,
    input  logic [WORD_W-1:0]      dataadr,
    input  logic [WORD_W-1:0]      writedata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_addr,
    output logic [WORD_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            overflow_cnt,
    output logic                   done,
    output logic                   fail
);

    logic                  lo_ok;
    logic                  hi_ok;
    logic                  push_req;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [2*WORD_W-1:0]   head;
    chk_state_e            state;
    chk_state_e            state_nxt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Open-ended window bounds collapse to constants so no always-true compare is built.
    generate
        if (WIN_LO == '0) begin : g_lo_open
            assign lo_ok = 1'b1;
        end else begin : g_lo_cmp
            assign lo_ok = (dataadr >= WIN_LO);
        end
        if (WIN_HI == '1) begin : g_hi_open
            assign hi_ok = 1'b1;
        end else begin : g_hi_cmp
            assign hi_ok = (dataadr <= WIN_HI);
        end
    endgenerate

    assign push_req = memwrite && lo_ok && hi_ok;
    assign pop      = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (2*WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_req),
        .wr_data ({dataadr, writedata}),
        .rd_en   (out_ready),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (count)
    );

    assign out_valid            = !fifo_empty;
    assign {out_addr, out_data} = head;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_cnt <= '0;
        end else if (push_req && fifo_full && !pop) begin
            overflow_cnt <= sat_inc16(overflow_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The first completion-address store decides; both verdicts are terminal.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        fail      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (memwrite && (dataadr == DONE_ADDR)) begin
                    state_nxt = (writedata == DONE_DATA) ? ST_PASS : ST_FAIL;
                end
            end
            ST_PASS: done = 1'b1;
            ST_FAIL: fail = 1'b1;
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_monitor.sv
// Randomised scoreboard bench for store_monitor: one full-range DEPTH=8 instance
// and one windowed (0x100..0x1FF) DEPTH=4 instance share the store bus.
module tb_store_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        rdy0 = 1'b0;
    logic        rdy1 = 1'b0;

    logic        ov0, ov1, done0, done1, fail0, fail1;
    logic [31:0] oa0, od0, oa1, od1;
    logic [3:0]  cnt0;
    logic [2:0]  cnt1;
    logic [15:0] ovf0, ovf1;

    always #5 clk = ~clk;

    store_monitor #(.DEPTH(8)) dut0 (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .out_valid(ov0), .out_ready(rdy0), .out_addr(oa0),
        .out_data(od0), .count(cnt0), .overflow_cnt(ovf0), .done(done0), .fail(fail0)
    );

    store_monitor #(.DEPTH(4), .WIN_LO(32'h100), .WIN_HI(32'h1FF)) dut1 (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .out_valid(ov1), .out_ready(rdy1), .out_addr(oa1),
        .out_data(od1), .count(cnt1), .overflow_cnt(ovf1), .done(done1), .fail(fail1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy, drop count, verdict (0 none, 1 done, 2 fail).
    int mocc[2] = '{0, 0};
    int movf[2] = '{0, 0};
    int mflag[2] = '{0, 0};
    int cur_cnt[2] = '{0, 0};
    int cur_ovf[2] = '{0, 0};
    int cur_flag[2] = '{0, 0};
    bit chk_en = 0;
    bit model_ok = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    function automatic int depth_of(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic bit in_win(input int k, input logic [31:0] a);
        if (k == 0) return 1'b1;
        return (a >= 32'h100) && (a <= 32'h1FF);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge and apply to the following edge.
    task automatic cycle(input logic r, input logic mw, input logic [31:0] a,
                         input logic [31:0] d, input logic r0, input logic r1);
        @(posedge clk);
        #1;
        reset = r; memwrite = mw; dataadr = a; writedata = d; rdy0 = r0; rdy1 = r1;
        for (int k = 0; k < 2; k++) begin
            bit pop;
            bit push;
            bit want;
            cur_cnt[k]  = mocc[k];
            cur_ovf[k]  = movf[k];
            cur_flag[k] = mflag[k];
            if (r) begin
                mocc[k] = 0; movf[k] = 0; mflag[k] = 0;
            end else begin
                pop  = (mocc[k] > 0) && ((k == 0) ? r0 : r1);
                want = mw && in_win(k, a);
                push = want && ((mocc[k] < depth_of(k)) || pop);
                if (want && !push && movf[k] < 65535) movf[k]++;
                if (push) begin
                    if (k == 0) q0.push_back({a, d});
                    else        q1.push_back({a, d});
                end
                mocc[k] = mocc[k] + int'(push) - int'(pop);
                if (mw && a == 32'd84 && mflag[k] == 0) mflag[k] = (d == 32'd7) ? 1 : 2;
            end
        end
        if (r) begin
            q0.delete();
            q1.delete();
        end
        chk_en = model_ok;
        if (r) model_ok = 1;
    endtask

    // Monitor: compare visible state and consume scoreboard entries on handshakes.
    always @(negedge clk) begin
        if (chk_en) begin
            check("count0", 64'(cnt0), 64'(cur_cnt[0]));
            check("count1", 64'(cnt1), 64'(cur_cnt[1]));
            check("valid0", 64'(ov0), 64'(cur_cnt[0] != 0));
            check("valid1", 64'(ov1), 64'(cur_cnt[1] != 0));
            check("ovf0", 64'(ovf0), 64'(cur_ovf[0]));
            check("ovf1", 64'(ovf1), 64'(cur_ovf[1]));
            check("done0", 64'(done0), 64'(cur_flag[0] == 1));
            check("fail0", 64'(fail0), 64'(cur_flag[0] == 2));
            check("done1", 64'(done1), 64'(cur_flag[1] == 1));
            check("fail1", 64'(fail1), 64'(cur_flag[1] == 2));
            if (!ov0) check("idle_head0", {oa0, od0}, 64'd0);
            if (!ov1) check("idle_head1", {oa1, od1}, 64'd0);
            if (!reset && ov0) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL head0: got %0h, expected no entry", {oa0, od0});
                end else begin
                    check("head0", {oa0, od0}, q0[0]);
                    if (rdy0) void'(q0.pop_front());
                end
            end
            if (!reset && ov1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL head1: got %0h, expected no entry", {oa1, od1});
                end else begin
                    check("head1", {oa1, od1}, q1[0]);
                    if (rdy1) void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;

        cycle(1, 0, 0, 0, 0, 0);
        // Single store becomes visible the cycle after capture.
        cycle(0, 1, 32'h10, 32'hAAAA, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);

        // Overfill, then a simultaneous store and pop on a full FIFO, then drain.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 32'h100 + 32'(4 * i), 32'h5000 + 32'(i), 0, 0);
        cycle(0, 1, 32'h180, 32'hBEEF, 1, 1);
        cycle(0, 0, 0, 0, 0, 0);
        repeat (10) cycle(0, 0, 0, 0, 1, 1);

        // Completion: pass then a later bad value; then fail first.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'd84, 32'd7, 0, 0);
        cycle(0, 1, 32'd84, 32'd5, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 1, 1);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'd84, 32'd5, 0, 0);
        cycle(0, 1, 32'd84, 32'd7, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 1, 1);

        // Window edges.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'hFC, 32'h1, 0, 0);
        cycle(0, 1, 32'h100, 32'h2, 0, 0);
        cycle(0, 1, 32'h1FF, 32'h3, 0, 0);
        cycle(0, 1, 32'h200, 32'h4, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0, 1, 1);

        // Reset with buffered entries and a coincident store.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'h140 + 32'(i), 32'h77 + 32'(i), 0, 0);
        cycle(0, 1, 32'd84, 32'd9, 0, 0);
        cycle(1, 1, 32'h150, 32'h1234, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);

        // Randomised traffic with occasional resets.
        repeat (500) begin
            case ($urandom_range(0, 6))
                0:       a = 32'h10;
                1:       a = 32'hFC;
                2:       a = 32'h100;
                3:       a = 32'h1FF;
                4:       a = 32'h200;
                5:       a = 32'd84;
                default: a = $urandom;
            endcase
            d = (a == 32'd84 && $urandom_range(0, 1) == 1) ? 32'd7 : $urandom;
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), a, d,
                  ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4));
        end

        repeat (12) cycle(0, 0, 0, 0, 1, 1);
        @(negedge clk);
        #1;
        check("drained0", 64'(q0.size()), 64'd0);
        check("drained1", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
